muldiv_divider: RTL

Iterative radix-2 integer divider implementing the RV64M division group (DIV, DIVU, REM, REMU and the W variants) for the RV64I core. Sits beside the 64-bit ALU in the execute stage: it takes the same source operands and hands its quotient or remainder to the execute result mux. The pipeline stalls on `busy`, holds the result until `done` and then writes it back. It runs one quotient bit per clock and resolves divide-by-zero and signed overflow on a fast path.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_divider_if.sv | 13 +
 rtl/div_step.sv | 18 +
 rtl/muldiv_divider.sv | 85 ++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings, state type and iteration counts for the divider
package muldiv_pkg;
  localparam int XLEN = 64;
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;
  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_funct_e;
  typedef enum logic [1:0] {S_IDLE, S_ITERATE, S_FINISH} div_state_e;
endpackage

// File: rtl/muldiv_divider_if.sv
// muldiv_divider_if: request/response bundle between execute stage and divider
interface muldiv_divider_if import muldiv_pkg::*; ;
  logic             start;
  div_funct_e       div_funct;
  logic             word;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  modport master (output start, div_funct, word, operand_a, operand_b, input busy, done, result);
  modport slave  (input start, div_funct, word, operand_a, operand_b, output busy, done, result);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step import muldiv_pkg::*; (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_quo_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_quo_bit
);
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  // shifted remainder needs XLEN+1 bits because an unsigned divisor can be near 2^64
  always_comb begin
    w_shift   = {i_rem, i_quo_msb};
    o_quo_bit = w_shift >= {1'b0, i_divisor};
    w_diff    = w_shift[XLEN-1:0] - i_divisor;
    o_rem     = o_quo_bit ? w_diff : w_shift[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative radix-2 RV64M divider (DIV/DIVU/REM/REMU and W forms)
module muldiv_divider import muldiv_pkg::*; (
  input logic            clock,
  input logic            reset,
  muldiv_divider_if.slave bus
);
  div_state_e      r_state, w_next;
  logic [1:0]      r_funct;
  logic            r_word, r_neg_q, r_neg_r, r_done;
  logic [XLEN-1:0] r_quo, r_rem, r_divisor, r_result;
  logic [6:0]      r_count;
  logic            w_signed, w_sa, w_sb, w_div0, w_ovf, w_quo_bit;
  logic [XLEN-1:0] w_a, w_b, w_abs_a, w_abs_b, w_rem_next, w_q, w_r, w_sel;
  // operand preparation: width selection, sign capture, magnitudes, fast-path detection
  always_comb begin
    w_signed = ~bus.div_funct[0];
    w_a      = bus.word ? {(w_signed ? {32{bus.operand_a[31]}} : 32'b0), bus.operand_a[31:0]} : bus.operand_a;
    w_b      = bus.word ? {(w_signed ? {32{bus.operand_b[31]}} : 32'b0), bus.operand_b[31:0]} : bus.operand_b;
    w_sa     = w_signed & w_a[XLEN-1];
    w_sb     = w_signed & w_b[XLEN-1];
    w_abs_a  = w_sa ? -w_a : w_a;
    w_abs_b  = w_sb ? -w_b : w_b;
    w_div0   = w_b == '0;
    w_ovf    = w_signed && (&w_b) && w_a == (bus.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000);
  end
  div_step u_step (
    .i_rem     (r_rem),
    .i_quo_msb (r_quo[XLEN-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo_bit (w_quo_bit)
  );
  // sign correction and quotient/remainder select for the FINISH cycle
  always_comb begin
    w_q   = r_neg_q ? -r_quo : r_quo;
    w_r   = r_neg_r ? -r_rem : r_rem;
    w_sel = r_funct[1] ? w_r : w_q;
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  // next state: ITERATE falls through to FINISH once the count is exhausted
  always_comb begin
    w_next = r_state == S_IDLE    ? (bus.start ? S_ITERATE : S_IDLE) :
             r_state == S_ITERATE ? (r_count == '0 ? S_FINISH : S_ITERATE) : S_IDLE;
  end
  // datapath: load on accepted start, shift/subtract while iterating, register result in FINISH
  always_ff @(posedge clock) begin
    if (reset) begin
      r_funct   <= '0;
      r_word    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_count   <= '0;
    end else begin
      r_done <= r_state == S_FINISH;
      if (r_state == S_IDLE && bus.start) begin
        r_funct   <= bus.div_funct;
        r_word    <= bus.word;
        r_neg_q   <= (w_sa ^ w_sb) & ~w_div0;
        r_neg_r   <= w_sa;
        r_divisor <= w_abs_b;
        r_count   <= (w_div0 || w_ovf) ? '0 : bus.word ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64);
        r_quo     <= w_div0 ? '1 : (bus.word && !w_ovf) ? {w_abs_a[31:0], 32'b0} : w_abs_a;
        r_rem     <= w_div0 ? w_abs_a : '0;
      end else if (r_state == S_ITERATE && r_count != '0) begin
        r_quo   <= {r_quo[XLEN-2:0], w_quo_bit};
        r_rem   <= w_rem_next;
        r_count <= r_count - 1'b1;
      end else if (r_state == S_FINISH) begin
        r_result <= r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
      end
    end
  end
  assign bus.busy   = r_state != S_IDLE;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule
